// File: rtl/cpu_pkg.sv
// cpu_pkg: widths, opcodes and fetch-state encoding shared by the CPU pipeline stages.
package cpu_pkg;
    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 8;
    localparam int OPCODE_W = 4;
    localparam logic [OPCODE_W-1:0] OPC_HALT = 4'hF;

    typedef enum logic {FETCH_RUN, FETCH_HALTED} fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPCODE_W];
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, instr} buffer between fetch and decode; flush beats push.
module fetch_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_q, rd_q;
    logic [1:0]   count_q;

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_i)
                rd_q <= ~rd_q;
            count_q <= count_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, reads a 1-cycle synchronous instruction memory and
// hands {instr, pc} to decode; supports redirect and stops issuing after HALT.
module fetch_stage #(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted
);
    import cpu_pkg::*;

    fetch_state_e              state_q;
    logic [ADDR_W-1:0]         pc_q, inflight_pc_q;
    logic                      inflight_q, pop, live_resp, halt_returning;
    logic [1:0]                count, occ_after_pop;
    logic [ADDR_W+INSTR_W-1:0] head;

    // A response survives only if nothing flushed or halted the stage since its issue.
    assign pop            = out_valid & out_ready;
    assign live_resp      = inflight_q & ~redirect_valid & (state_q == FETCH_RUN);
    assign halt_returning = live_resp & (imem_rdata[INSTR_W-1 -: OPCODE_W] == OPC_HALT);
    assign occ_after_pop  = count + {1'b0, inflight_q} - {1'b0, pop};
    assign imem_en        = ~reset & (state_q == FETCH_RUN) & ~redirect_valid
                          & ~halt_returning & (occ_after_pop < 2'd2);
    assign imem_addr      = pc_q;
    assign out_valid      = count != 2'd0;
    assign {out_pc, out_instr} = head;
    assign halted         = state_q == FETCH_HALTED;

    fetch_fifo #(.W(ADDR_W + INSTR_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (live_resp),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({inflight_pc_q, imem_rdata}),
        .count_o (count),
        .head_o  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH_RUN;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            state_q    <= FETCH_RUN;
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_en;
            if (imem_en) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + ADDR_W'(1);
            end
            // Resume point after a later redirect-free restart is the word after HALT.
            if (halt_returning) begin
                state_q <= FETCH_HALTED;
                pc_q    <= inflight_pc_q + ADDR_W'(1);
            end
        end
    end
endmodule
